// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for the pong ball datapath.
// Holds, re-centres and releases the ball, picks the serve direction, keeps
// both scores and declares game over. All game timing counts VSYNC frames.
// Optional feature macro: SPEED_RAMP_EN (paddle-hit driven ball speed ramp).
// With SPEED_RAMP_EN undefined the ball speed is a constant 1 and
// paddle_hit is ignored.
module pong_game_ctrl #(
    parameter int SCORE_W       = 4,
    parameter int WIN_SCORE     = 7,
    parameter int SERVE_FRAMES  = 60,
    parameter int POINT_FRAMES  = 90,
    parameter int HITS_PER_STEP = 4,
    parameter int MAX_SPEED     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               VSYNC,
    input  logic               start,
    input  logic               miss_left,
    input  logic               miss_right,
    input  logic               paddle_hit,
    output logic               ball_hold,
    output logic               ball_center,
    output logic               serve_dir_x,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic [2:0]         state,
    output logic [2:0]         ball_speed
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam int FRAME_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W     = $clog2(FRAME_MAX + 1);

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               serve_dir_q, serve_dir_d;
    logic               ball_center_q, ball_center_d;
    logic               vsync_q;
    logic               frame_tick;
    logic               serve_entry;
    logic               win_reached;

    assign frame_tick  = VSYNC & ~vsync_q;
    assign win_reached = (score_l_q == WIN_VAL) || (score_r_q == WIN_VAL);

    // Next-state, frame counter and score logic of the game sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_dir_d = serve_dir_q;
        serve_entry = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    serve_dir_d = 1'b0;
                    frame_cnt_d = '0;
                    serve_entry = 1'b1;
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (frame_cnt_q == SERVE_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = ST_PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (miss_left || miss_right) begin
                    frame_cnt_d = '0;
                    state_d     = ST_POINT;
                    // A double miss scores nobody; a single miss serves toward the conceder.
                    if (miss_left && !miss_right) begin
                        if (score_r_q != WIN_VAL) score_r_d = score_r_q + 1'b1;
                        serve_dir_d = 1'b1;
                    end else if (miss_right && !miss_left) begin
                        if (score_l_q != WIN_VAL) score_l_d = score_l_q + 1'b1;
                        serve_dir_d = 1'b0;
                    end
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (frame_cnt_q == POINT_LAST) begin
                        frame_cnt_d = '0;
                        if (win_reached) begin
                            state_d = ST_OVER;
                        end else begin
                            serve_entry = 1'b1;
                            state_d     = ST_SERVE;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                frame_cnt_d = '0;
                state_d     = ST_IDLE;
            end
        endcase

        // Registered so the pulse coincides with the first cycle in SERVE.
        ball_center_d = serve_entry;
    end

    // Game state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            frame_cnt_q   <= '0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            serve_dir_q   <= 1'b0;
            ball_center_q <= 1'b0;
            vsync_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            serve_dir_q   <= serve_dir_d;
            ball_center_q <= ball_center_d;
            vsync_q       <= VSYNC;
        end
    end

`ifdef SPEED_RAMP_EN
    localparam int HIT_W = $clog2(HITS_PER_STEP + 1);

    localparam logic [HIT_W-1:0] HIT_LAST  = HIT_W'(HITS_PER_STEP - 1);
    localparam logic [2:0]       SPEED_TOP = 3'(MAX_SPEED);

    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [2:0]       speed_q, speed_d;

    // Paddle-hit counter steps the speed every HITS_PER_STEP hits; each serve restarts at 1.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        speed_d   = speed_q;
        if (serve_entry) begin
            hit_cnt_d = '0;
            speed_d   = 3'd1;
        end else if ((state_q == ST_PLAY) && paddle_hit) begin
            if (hit_cnt_q == HIT_LAST) begin
                hit_cnt_d = '0;
                if (speed_q < SPEED_TOP) speed_d = speed_q + 3'd1;
            end else begin
                hit_cnt_d = hit_cnt_q + 1'b1;
            end
        end
    end

    // Speed ramp registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
            speed_q   <= 3'd1;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            speed_q   <= speed_d;
        end
    end

    assign ball_speed = speed_q;
`else
    // Without the ramp the ball runs at a fixed speed and paddle hits are irrelevant.
    logic [1:0] unused_ramp_inputs;
    assign unused_ramp_inputs = {paddle_hit, (HITS_PER_STEP > MAX_SPEED)};
    assign ball_speed         = 3'd1;
`endif

    assign ball_hold   = (state_q != ST_PLAY);
    assign game_over   = (state_q == ST_OVER);
    assign ball_center = ball_center_q;
    assign serve_dir_x = serve_dir_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign state       = state_q;

endmodule
